// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage register.
// Revision    : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int CTRL_WREG   = 0;
    localparam int CTRL_M2REG  = 1;
    localparam int CTRL_WMEM   = 2;
    localparam int CTRL_BRANCH = 3;
    localparam int CTRL_ZERO   = 4;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CTRL_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Unsigned up-counter that sticks at its all-ones value.
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + C_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline stage with 2-entry skid, flush and
//               bubble-gated control bits plus saturating debug counters.
// Revision    : 1.0
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_BUSY  = BUSY;
    localparam logic [1:0] ST_FULL  = FULL;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic w_accept;
    logic w_consume;
    logic w_stall_inc;
    logic w_flush_inc;

    // Handshake outputs decode straight from the state flop: no comb path from out_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d     = ST_BUSY;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_consume) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (w_accept) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (w_consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        state_d     = ST_BUSY;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign w_stall_inc = out_valid & ~out_ready;
    assign w_flush_inc = flush & (state_q != ST_EMPTY);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed, table-driven bench for pipe_stage_skid (CNT_W=4).
// Revision    : 1.0
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic [7:0]  c;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_d;
        logic [7:0]  e_c;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                         input logic [7:0] c, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    initial begin
        // Outputs seen at the negedge of vector i, then its inputs are applied for the next edge.
        //            fl    iv    d      c      or    e_ov  e_ir  e_d    e_c
        vecs[0]  = '{1'b0, 1'b1, 32'h10, 8'h01, 1'b1, 1'b0, 1'b1, 32'h0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h11, 8'h02, 1'b1, 1'b1, 1'b1, 32'h10, 8'h01};
        vecs[2]  = '{1'b0, 1'b1, 32'h12, 8'h03, 1'b1, 1'b1, 1'b1, 32'h11, 8'h02};
        vecs[3]  = '{1'b0, 1'b1, 32'h13, 8'h04, 1'b1, 1'b1, 1'b1, 32'h12, 8'h03};
        vecs[4]  = '{1'b0, 1'b0, 32'h00, 8'h00, 1'b1, 1'b1, 1'b1, 32'h13, 8'h04};
        vecs[5]  = '{1'b0, 1'b1, 32'h0A, 8'h05, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 32'h0B, 8'h06, 1'b0, 1'b1, 1'b1, 32'h0A, 8'h05};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0A, 8'h05};
        vecs[8]  = '{1'b0, 1'b1, 32'hEE, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0A, 8'h05};
        vecs[9]  = '{1'b0, 1'b0, 32'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0A, 8'h05};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0B, 8'h06};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0, 8'h00};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
        chk("reset_out_ctrl", {24'b0, out_ctrl}, 32'h0);
        chk("reset_stall_cnt", {28'b0, stall_cnt}, 32'h0);
        chk("reset_flush_cnt", {28'b0, flush_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming (vectors 0-4) then skid fill and in-order drain (5-12).
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
            chk($sformatf("v%0d_out_ctrl", i), {24'b0, out_ctrl}, {24'b0, vecs[i].e_c});
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
            end
            if (i == 5) begin
                chk("stream_stall_cnt", {28'b0, stall_cnt}, 32'h0);
            end
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy);
        end
        @(negedge clk);
        chk("skid_stall_cnt", {28'b0, stall_cnt}, 32'd3);
        chk("skid_flush_cnt", {28'b0, flush_cnt}, 32'd0);

        // Flush while FULL with a same-cycle accept that must be dropped.
        drive(1'b0, 1'b1, 32'h1, 8'h07, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h2, 8'h07, 1'b0);
        @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        chk("full_out_data", out_data, 32'h1);
        drive(1'b1, 1'b1, 32'h0C, 8'h07, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_out_ctrl", {24'b0, out_ctrl}, 32'h0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
        chk("flush_cnt_one", {28'b0, flush_cnt}, 32'd1);
        chk("flush_stall_cnt", {28'b0, stall_cnt}, 32'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_flush_idle%0d", k), {31'b0, out_valid}, 32'h0);
        end
        drive(1'b1, 1'b0, 32'h0, 8'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
        @(negedge clk);
        chk("empty_flush_cnt", {28'b0, flush_cnt}, 32'd1);

        // Asynchronous reset while FULL with ctrl 07.
        drive(1'b0, 1'b1, 32'h21, 8'h07, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h22, 8'h07, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        chk("pre_rst_full", {31'b0, in_ready}, 32'h0);
        chk("pre_rst_ctrl", {24'b0, out_ctrl}, 32'h07);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_out_ctrl", {24'b0, out_ctrl}, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("arst_stall_cnt", {28'b0, stall_cnt}, 32'h0);
        chk("arst_flush_cnt", {28'b0, flush_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stall saturation: one held entry, 20 stalled cycles.
        drive(1'b0, 1'b1, 32'h55, 8'h01, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        repeat (14) @(negedge clk);
        chk("stall_cnt_14", {28'b0, stall_cnt}, 32'd14);
        repeat (6) @(negedge clk);
        chk("stall_cnt_sat", {28'b0, stall_cnt}, 32'd15);
        chk("stall_hold_data", out_data, 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
